// File: rtl/sr_fetch_pkg.sv
// Shared definitions for the sr_cpu instruction fetch stage: memory timing,
// PC stride and the prefetch FIFO entry layout.
package sr_fetch_pkg;

  localparam int          IM_LATENCY = 1;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/sr_fifo.sv
// Synchronous FIFO with flush; push is ignored when full, pop when empty.
// Storage resets to zero so the head reads as zero out of reset.
module sr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == (AW+1)'(0));
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else if (flush) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/sr_ifetch_queue.sv
// Fetch stage: owns the fetch PC, issues 1-cycle-latency instruction reads and
// buffers {instr, pc} in a prefetch FIFO; redirect flushes and restarts fetch.
module sr_ifetch_queue
  import sr_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  fetch_pc_r;
  logic [31:0]  pc_q_r;
  logic         inflight_r;
  logic         kill_r;
  logic [CW-1:0] count_s;
  logic [CW-1:0] occupancy_s;
  logic         push_s;
  logic         pop_s;
  logic         full_s;
  logic         empty_s;
  fetch_entry_t wr_entry_s;
  fetch_entry_t head_s;

  // A slot is reserved at issue, so queued plus in-flight never exceeds DEPTH.
  assign occupancy_s = count_s + CW'(inflight_r);
  assign im_req      = rst_n & ~redirect_valid & ~full_s & (occupancy_s < CW'(DEPTH));
  assign im_addr     = fetch_pc_r >> 2;

  assign wr_entry_s.instr = im_data;
  assign wr_entry_s.pc    = pc_q_r;
  assign push_s           = inflight_r & ~kill_r & ~redirect_valid;
  assign pop_s            = instr_valid & instr_ready;

  assign instr_valid = ~empty_s;
  assign instr       = head_s.instr;
  assign instr_pc    = head_s.pc;

  // Fetch PC, in-flight tracking and response kill after redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      pc_q_r     <= 32'h0000_0000;
      inflight_r <= 1'b0;
      kill_r     <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_pc & 32'hFFFF_FFFC;
      inflight_r <= 1'b0;
      kill_r     <= inflight_r;
    end else begin
      inflight_r <= im_req;
      kill_r     <= 1'b0;
      if (im_req) begin
        pc_q_r     <= fetch_pc_r;
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
    end
  end

  sr_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .wdata (wr_entry_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

endmodule

// File: tb/tb_sr_ifetch_queue.sv
// Scoreboard bench for sr_ifetch_queue: stimulus pushes expected PCs, a monitor
// compares every decode handshake against the queue.
module tb_sr_ifetch_queue;

  localparam logic [31:0] SALT = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_data = 32'h0000_0000;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  sr_ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_data        (im_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  // Instruction memory: word at byte address A is A ^ SALT, one cycle latency.
  always @(posedge clk) begin
    im_data <= im_req ? ((im_addr << 2) ^ SALT) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every accepted instruction must match the next expected PC.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (rst_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual_pc=%h required=none", instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", instr_pc, e);
        chk("pop_instr", instr, e ^ SALT);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    #1;
    chk("rst_im_req", {31'd0, im_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    step();
    step();
    exp_q.delete();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic drain(input string name, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout actual=%0d_left required=0", name, exp_q.size());
      exp_q.delete();
    end
    instr_ready = 1'b0;
  endtask

  initial begin : stim
    int n;
    int nreq;

    // 1: streaming from reset, one instruction per cycle
    reset_dut();
    instr_ready = 1'b1;
    chk("t1_first_req", {31'd0, im_req}, 32'd1);
    chk("t1_first_addr", im_addr, 32'd0);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    step();
    chk("t1_valid_c1", {31'd0, instr_valid}, 32'd0);
    step();
    chk("t1_valid_c2", {31'd0, instr_valid}, 32'd1);
    drain("t1", n);
    chk("t1_rate", 32'(n), 32'd6);

    // 2: decode stalled, queue fills to DEPTH and head holds
    reset_dut();
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (im_req) begin
        chk("t2_addr", im_addr, 32'(nreq));
        nreq++;
      end
      if (instr_valid) chk("t2_hold_pc", instr_pc, 32'h0);
      step();
    end
    chk("t2_nreq", 32'(nreq), 32'd4);
    chk("t2_req_off", {31'd0, im_req}, 32'd0);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    instr_ready = 1'b1;
    drain("t2", n);

    // 3: redirect with 3 queued and one in flight
    reset_dut();
    n = 0;
    while (!(!im_req && instr_valid) && n < 20) begin
      step();
      n++;
    end
    chk("t3_setup_cycles", 32'(n), 32'd4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    #1;
    chk("t3_req_in_redirect", {31'd0, im_req}, 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t3_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("t3_req", {31'd0, im_req}, 32'd1);
    chk("t3_addr", im_addr, 32'h40);
    exp_q = '{32'h100, 32'h104, 32'h108};
    instr_ready = 1'b1;
    drain("t3", n);

    // 4: unaligned redirect target
    reset_dut();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t4_req", {31'd0, im_req}, 32'd1);
    chk("t4_addr", im_addr, 32'h80);
    exp_q = '{32'h200, 32'h204};
    instr_ready = 1'b1;
    drain("t4", n);

    // 5: back-to-back redirects, last one wins
    reset_dut();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    step();
    redirect_pc = 32'h0000_0080;
    #1;
    chk("t5_req_off", {31'd0, im_req}, 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("t5_req", {31'd0, im_req}, 32'd1);
    chk("t5_addr", im_addr, 32'h20);
    chk("t5_valid", {31'd0, instr_valid}, 32'd0);
    exp_q = '{32'h80, 32'h84, 32'h88};
    instr_ready = 1'b1;
    drain("t5", n);

    // 6: asynchronous reset with a full FIFO
    reset_dut();
    for (int i = 0; i < 8; i++) step();
    chk("t6_full_req", {31'd0, im_req}, 32'd0);
    chk("t6_full_valid", {31'd0, instr_valid}, 32'd1);
    reset_dut();
    chk("t6_restart_req", {31'd0, im_req}, 32'd1);
    chk("t6_restart_addr", im_addr, 32'd0);
    exp_q = '{32'h0, 32'h4, 32'h8};
    instr_ready = 1'b1;
    drain("t6", n);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
